enc_pwm_mixer: RTL and testbench

//   Parametrised N-channel rotary-encoder-to-PWM mixer core. Successor to the

---
 rtl/enc_pwm_mixer_pkg.sv | 18 +
 rtl/enc_pwm_mixer_channel.sv | 88 ++++++++
 rtl/enc_pwm_mixer.sv | 82 ++++++++
 tb/tb_enc_pwm_mixer.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/enc_pwm_mixer_pkg.sv
// Shared definitions for the encoder-to-PWM mixer: default widths, the
// encoder direction encoding and the readback select width helper.
package enc_pwm_mixer_pkg;

    localparam int DEF_CNT_W = 8;
    localparam int DEF_DB_W  = 4;

    // Debounced B level at the moment A rises.
    typedef enum logic {
        DIR_UP = 1'b0,
        DIR_DN = 1'b1
    } dir_e;

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/enc_pwm_mixer_channel.sv
// One encoder channel: 2-FF synchronisers, strobe-sampled debounce,
// A-rise decode and the saturating/wrapping level register.
module enc_channel
    import enc_pwm_mixer_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int WRAP  = 0,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             strobe,
    input  logic             enc_a,
    input  logic             enc_b,
    output logic [CNT_W-1:0] level,
    output logic             step_p
);

    localparam logic [CNT_W:0] STEP_V = (CNT_W+1)'(STEP);

    logic [1:0]       a_sync_reg, b_sync_reg;
    logic             a_samp_reg, b_samp_reg;
    logic             a_db_reg, b_db_reg;
    logic             resync_reg;
    logic [CNT_W-1:0] level_reg, level_next;
    logic             step_reg;

    logic             a_sync, b_sync, a_db_next, b_db_next, rise, changed;
    logic [CNT_W:0]   sum, diff;
    logic [CNT_W-1:0] cand;
    dir_e             dir;

    always_comb begin
        a_sync    = a_sync_reg[1];
        b_sync    = b_sync_reg[1];
        a_db_next = (a_sync == a_samp_reg) ? a_sync : a_db_reg;
        b_db_next = (b_sync == b_samp_reg) ? b_sync : b_db_reg;
        // The first strobe after a disable only resamples, so edges seen while off are dropped.
        rise      = strobe && !resync_reg && a_db_next && !a_db_reg;
        dir       = dir_e'(b_db_next);
        sum       = {1'b0, level_reg} + STEP_V;
        diff      = {1'b0, level_reg} - STEP_V;
        if (dir == DIR_UP)
            cand = (sum[CNT_W] && (WRAP == 0)) ? '1 : sum[CNT_W-1:0];
        else
            cand = (diff[CNT_W] && (WRAP == 0)) ? '0 : diff[CNT_W-1:0];
        level_next = rise ? cand : level_reg;
        changed    = rise && (cand != level_reg);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sync_reg <= '0;
            b_sync_reg <= '0;
            a_samp_reg <= 1'b0;
            b_samp_reg <= 1'b0;
            a_db_reg   <= 1'b0;
            b_db_reg   <= 1'b0;
            resync_reg <= 1'b0;
            level_reg  <= '0;
            step_reg   <= 1'b0;
        end else begin
            a_sync_reg <= {a_sync_reg[0], enc_a};
            b_sync_reg <= {b_sync_reg[0], enc_b};
            if (!ena) begin
                resync_reg <= 1'b1;
            end else if (strobe) begin
                a_samp_reg <= a_sync;
                b_samp_reg <= b_sync;
                if (resync_reg) begin
                    a_db_reg   <= a_sync;
                    b_db_reg   <= b_sync;
                    resync_reg <= 1'b0;
                end else begin
                    a_db_reg <= a_db_next;
                    b_db_reg <= b_db_next;
                end
            end
            level_reg <= level_next;
            step_reg  <= changed;
        end
    end

    assign level  = level_reg;
    assign step_p = step_reg;

endmodule

// File: rtl/enc_pwm_mixer.sv
// N-channel encoder-to-PWM mixer: shared debounce prescaler and PWM counter,
// per-channel comparators and the registered level readback mux.
module enc_pwm_mixer
    import enc_pwm_mixer_pkg::*;
#(
    parameter int NUM_CH = 3,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int DB_W   = DEF_DB_W,
    parameter int WRAP   = 0,
    parameter int STEP   = 1,
    localparam int SEL_W = sel_width(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [NUM_CH-1:0] enc_a,
    input  logic [NUM_CH-1:0] enc_b,
    input  logic [SEL_W-1:0]  sel,
    output logic [NUM_CH-1:0] pwm_out,
    output logic [CNT_W-1:0]  level_o,
    output logic [NUM_CH-1:0] step_p
);

    logic [DB_W-1:0]   presc_reg;
    logic [CNT_W-1:0]  pwm_cnt_reg;
    logic [NUM_CH-1:0] pwm_reg;
    logic [CNT_W-1:0]  level_o_reg, level_o_next;
    logic              strobe;
    logic [NUM_CH-1:0] cmp;
    logic [CNT_W-1:0]  level_w [NUM_CH];

    // Strobe fires in the cycle the prescaler wraps back to 0.
    assign strobe = ena && (presc_reg == '1);

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            enc_channel #(
                .CNT_W (CNT_W),
                .WRAP  (WRAP),
                .STEP  (STEP)
            ) u_ch (
                .clk    (clk),
                .rst_n  (rst_n),
                .ena    (ena),
                .strobe (strobe),
                .enc_a  (enc_a[gi]),
                .enc_b  (enc_b[gi]),
                .level  (level_w[gi]),
                .step_p (step_p[gi])
            );
            assign cmp[gi] = (pwm_cnt_reg < level_w[gi]);
        end
    endgenerate

    always_comb begin
        level_o_next = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (sel == SEL_W'(i))
                level_o_next = level_w[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_reg   <= '0;
            pwm_cnt_reg <= '0;
            pwm_reg     <= '0;
            level_o_reg <= '0;
        end else begin
            if (ena) begin
                presc_reg   <= presc_reg + 1'b1;
                pwm_cnt_reg <= pwm_cnt_reg + 1'b1;
            end
            pwm_reg     <= ena ? cmp : '0;
            level_o_reg <= level_o_next;
        end
    end

    assign pwm_out = pwm_reg;
    assign level_o = level_o_reg;

endmodule

// File: tb/tb_enc_pwm_mixer.sv
// Self-checking bench for enc_pwm_mixer: three instances (saturating, wrapping,
// 8-channel 4-bit STEP=3) checked every settled cycle against an arithmetic model.
module tb_enc_pwm_mixer;
    import enc_pwm_mixer_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic [2:0] enc_a = '0, enc_b = '0;
    logic [1:0] sel = '0;
    logic [7:0] pa = '0, pb = '0;
    logic [2:0] sel_p = '0;

    logic [2:0] pwm_a, step_a, pwm_w, step_w;
    logic [7:0] lo_a, lo_w;
    logic [7:0] pwm_p, step_pp;
    logic [3:0] lo_p;

    always #5 clk = ~clk;

    enc_pwm_mixer #(.NUM_CH(3), .CNT_W(8), .DB_W(4), .WRAP(0), .STEP(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .ena(ena), .enc_a(enc_a), .enc_b(enc_b), .sel(sel),
        .pwm_out(pwm_a), .level_o(lo_a), .step_p(step_a));
    enc_pwm_mixer #(.NUM_CH(3), .CNT_W(8), .DB_W(4), .WRAP(1), .STEP(1)) dut_w (
        .clk(clk), .rst_n(rst_n), .ena(ena), .enc_a(enc_a), .enc_b(enc_b), .sel(sel),
        .pwm_out(pwm_w), .level_o(lo_w), .step_p(step_w));
    enc_pwm_mixer #(.NUM_CH(8), .CNT_W(4), .DB_W(4), .WRAP(0), .STEP(3)) dut_p (
        .clk(clk), .rst_n(rst_n), .ena(ena), .enc_a(pa), .enc_b(pb), .sel(sel_p),
        .pwm_out(pwm_p), .level_o(lo_p), .step_p(step_pp));

    // Model state: levels, expected and observed pulse counts.
    int lvl_a[3], lvl_w[3], lvl_p[8];
    int ex_a[3], ex_w[3], ex_p[8];
    int sc_a[3], sc_w[3], sc_p[8];
    int all3_cnt = 0;
    int mcnt8, mcnt4;
    logic [2:0] e_pwm_a, e_pwm_w;
    logic [7:0] e_pwm_p;
    int e_lo_a, e_lo_w, e_lo_p;
    bit settled = 0, rnd_sel = 0;
    int n_chk = 0, n_fail = 0;

    function automatic int nxt(input int l, input bit dn, input int w, input bit wrap, input int step);
        int m, r;
        m = 1 << w;
        r = dn ? l - step : l + step;
        if (wrap) return ((r % m) + m) % m;
        if (r < 0) return 0;
        if (r > m - 1) return m - 1;
        return r;
    endfunction

    // Expected registered outputs: pwm = (enabled-cycle count mod 2**W) < level; readback delayed 1 cycle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcnt8 <= 0; mcnt4 <= 0;
            e_pwm_a <= '0; e_pwm_w <= '0; e_pwm_p <= '0;
            e_lo_a <= 0; e_lo_w <= 0; e_lo_p <= 0;
        end else begin
            if (ena) begin
                mcnt8 <= (mcnt8 + 1) % 256;
                mcnt4 <= (mcnt4 + 1) % 16;
            end
            for (int i = 0; i < 3; i++) begin
                e_pwm_a[i] <= ena && (mcnt8 < lvl_a[i]);
                e_pwm_w[i] <= ena && (mcnt8 < lvl_w[i]);
            end
            for (int i = 0; i < 8; i++) e_pwm_p[i] <= ena && (mcnt4 < lvl_p[i]);
            e_lo_a <= (sel < 3) ? lvl_a[sel] : 0;
            e_lo_w <= (sel < 3) ? lvl_w[sel] : 0;
            e_lo_p <= lvl_p[sel_p];
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            sc_a[i] <= sc_a[i] + int'(step_a[i]);
            sc_w[i] <= sc_w[i] + int'(step_w[i]);
        end
        for (int i = 0; i < 8; i++) sc_p[i] <= sc_p[i] + int'(step_pp[i]);
        if (step_a == 3'b111) all3_cnt <= all3_cnt + 1;
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            if (n_fail <= 30) $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            if (rst_n && settled) begin
                chk("pwm_a", int'(pwm_a), int'(e_pwm_a));
                chk("pwm_w", int'(pwm_w), int'(e_pwm_w));
                chk("pwm_p", int'(pwm_p), int'(e_pwm_p));
                chk("step_a_idle", int'(step_a), 0);
                chk("step_w_idle", int'(step_w), 0);
                chk("step_p_idle", int'(step_pp), 0);
                chk("lo_a", int'(lo_a), e_lo_a);
                chk("lo_w", int'(lo_w), e_lo_w);
                chk("lo_p", int'(lo_p), e_lo_p);
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            if (rnd_sel) begin
                sel   = 2'($urandom_range(0, 3));
                sel_p = 3'($urandom_range(0, 7));
            end
        end
    endtask

    task automatic check_steps();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("steps_a%0d", i), sc_a[i], ex_a[i]);
            chk($sformatf("steps_w%0d", i), sc_w[i], ex_w[i]);
        end
        for (int i = 0; i < 8; i++) chk($sformatf("steps_p%0d", i), sc_p[i], ex_p[i]);
    endtask

    task automatic model_rise(input logic [2:0] m, input logic [2:0] d, input logic [7:0] pm, input logic [7:0] pd);
        int nl;
        for (int i = 0; i < 3; i++) if (m[i]) begin
            nl = nxt(lvl_a[i], d[i] == DIR_DN, 8, 0, 1);
            if (nl != lvl_a[i]) ex_a[i]++;
            lvl_a[i] = nl;
            nl = nxt(lvl_w[i], d[i] == DIR_DN, 8, 1, 1);
            if (nl != lvl_w[i]) ex_w[i]++;
            lvl_w[i] = nl;
        end
        for (int i = 0; i < 8; i++) if (pm[i]) begin
            nl = nxt(lvl_p[i], pd[i] == DIR_DN, 4, 0, 3);
            if (nl != lvl_p[i]) ex_p[i]++;
            lvl_p[i] = nl;
        end
    endtask

    task automatic detent(input logic [2:0] m, input logic [2:0] d, input logic [7:0] pm, input logic [7:0] pd);
        logic [2:0] nb;
        logic [7:0] npb;
        nb  = (enc_b & ~m) | (d & m);
        npb = (pb & ~pm) | (pd & pm);
        if (nb != enc_b || npb != pb) begin
            @(negedge clk);
            enc_b = nb; pb = npb;
            idle(40);
        end
        @(negedge clk);
        settled = 0;
        enc_a = enc_a | m; pa = pa | pm;
        model_rise(m, d, pm, pd);
        idle(40);
        settled = 1;
        check_steps();
        @(negedge clk);
        enc_a = enc_a & ~m; pa = pa & ~pm;
        idle(40);
    endtask

    task automatic clear_model();
        for (int i = 0; i < 3; i++) begin lvl_a[i] = 0; lvl_w[i] = 0; end
        for (int i = 0; i < 8; i++) lvl_p[i] = 0;
    endtask

    task automatic readback(input logic [1:0] s);
        @(negedge clk);
        sel = s;
        idle(2);
    endtask

    initial begin
        int hc, base;
        fork compare_loop(); join_none
        clear_model();

        // Reset held for 3 cycles, then released; everything must read 0.
        repeat (3) @(negedge clk);
        chk("rst_pwm_a", int'(pwm_a), 0);
        chk("rst_lo_a", int'(lo_a), 0);
        chk("rst_step_a", int'(step_a), 0);
        rst_n = 1'b1; ena = 1'b1;
        @(negedge clk);
        chk("rel_pwm_p", int'(pwm_p), 0);
        chk("rel_lo_p", int'(lo_p), 0);
        chk("rel_step_w", int'(step_w), 0);
        settled = 1;
        hc = 0;
        repeat (256) begin @(negedge clk); hc += int'(|{pwm_a, pwm_w, pwm_p}); end
        chk("rst_pwm_quiet", hc, 0);

        // Decrement from 0: clamps when saturating, wraps otherwise.
        repeat (3) detent(3'b001, 3'b001, 8'h00, 8'h00);
        readback(2'd0);
        chk("sat_low_lo", int'(lo_a), 0);
        chk("wrap_low_lo", int'(lo_w), 253);
        chk("sat_low_steps", sc_a[0], 0);
        repeat (260) detent(3'b001, 3'b000, 8'h00, 8'h00);
        readback(2'd0);
        chk("sat_high_lo", int'(lo_a), 255);

        // Asynchronous reset mid-period clears outputs without a clock.
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_pwm_a", int'(pwm_a), 0);
        chk("async_lo_a", int'(lo_a), 0);
        clear_model();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(4);

        // Five clean increments on channel 0.
        base = sc_a[0];
        repeat (5) detent(3'b001, 3'b000, 8'h00, 8'h00);
        readback(2'd0);
        chk("inc5_lo", int'(lo_a), 5);
        chk("inc5_steps", sc_a[0] - base, 5);
        hc = 0;
        repeat (256) begin @(negedge clk); hc += int'(pwm_a[0]); end
        chk("inc5_duty", hc, 5);

        // Contact bounce on A resolves to a single increment.
        @(negedge clk);
        settled = 0;
        model_rise(3'b001, 3'b000, 8'h00, 8'h00);
        for (int c = 0; c < 40; c++) begin
            if (c % 3 == 0) enc_a[0] = ~enc_a[0];
            @(negedge clk);
        end
        enc_a[0] = 1'b1;
        idle(45);
        settled = 1;
        check_steps();
        @(negedge clk); enc_a[0] = 1'b0;
        idle(40);
        readback(2'd0);
        chk("bounce_lo", int'(lo_a), 6);

        // All three channels see an edge in the same cycle.
        base = all3_cnt;
        detent(3'b111, 3'b000, 8'h00, 8'h00);
        chk("simul_pulse", all3_cnt - base, 1);

        // Disabled for 500 cycles while the encoders move.
        hc = 0;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            if (c > 0) hc += int'(|{pwm_a, pwm_w, pwm_p});
            ena = 1'b0;
            if (c < 480 && c % 7 == 0) begin
                enc_a = 3'($urandom); enc_b = 3'($urandom);
                pa = 8'($urandom); pb = 8'($urandom);
            end else if (c >= 480) begin
                enc_a = '0; enc_b = '0; pa = '0; pb = '0;
            end
        end
        @(negedge clk); ena = 1'b1;
        idle(60);
        chk("ena_off_pwm", hc, 0);
        readback(2'd0);
        chk("ena_off_lo", int'(lo_a), 7);
        check_steps();

        // Randomized detents with random masks, directions and readback selects.
        rnd_sel = 1;
        repeat (30) detent(3'($urandom_range(1, 7)), 3'($urandom), 8'h00, 8'h00);
        rnd_sel = 0;
        readback(2'd3);
        chk("sel_oob_lo", int'(lo_a), 0);

        // 8-channel, 4-bit, STEP=3 instance: six increments clamp at 15.
        repeat (6) detent(3'b000, 3'b000, 8'hFF, 8'h00);
        @(negedge clk); sel_p = 3'd0; idle(2);
        chk("p_ch0_lo", int'(lo_p), 15);
        @(negedge clk); sel_p = 3'd7; idle(2);
        chk("p_ch7_lo", int'(lo_p), 15);
        chk("p_ch0_steps", sc_p[0], 5);
        hc = 0;
        repeat (16) begin @(negedge clk); hc += int'(pwm_p[0]); end
        chk("p_duty", hc, 15);

        settled = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
